axi_burst_master: RTL and testbench

- Parametrised successor of the single-beat CPU-side AXI master. Converts one CPU/cache request into a single AXI4 read or write burst of 1..MAX_BEATS beats, either INCR or (optionally) WRAP.
- Raises stall toward the core while a transaction is in flight.
- Sits between the CPU/cache and the AXI bridge. IM and DM ports each get one instance.

---
 rtl/axi_burst_master.sv | 164 ++++++++++++++++
 tb/tb_axi_burst_master.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// axi_burst_master: turns one CPU/cache request into a single AXI4 read or write burst of 1..MAX_BEATS beats.
// Define AXI_BURST_WRAP_EN to allow WRAP bursts for critical-word-first refill; otherwise every burst is INCR.
module axi_burst_master #(
    parameter logic [3:0] AXI_ID    = 4'd0,
    parameter int         DATA_W    = 32,
    parameter int         ADDR_W    = 32,
    parameter int         MAX_BEATS = 4,
    localparam int        STRB_W    = DATA_W / 8,
    localparam int        BW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BW-1:0]     req_len,
    input  logic [STRB_W-1:0] req_strb,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_wrap,
    output logic              stall,
    output logic              done,
    output logic [1:0]        err,
    output logic              rbeat_valid,
    output logic [BW-1:0]     rbeat_idx,
    output logic [DATA_W-1:0] rbeat_data,
    output logic [BW-1:0]     wbeat_idx,
    output logic [3:0]        ARID,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [3:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [3:0]        RID,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [3:0]        AWID,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [3:0]        AWLEN,
    output logic [2:0]        AWSIZE,
    output logic [1:0]        AWBURST,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WLAST,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [3:0]        BID,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY
);
    localparam int SZ = $clog2(STRB_W);
    localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(STRB_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BW-1:0]     len_q;
    logic [BW-1:0]     cnt_q;
    logic [1:0]        err_q;
    logic [1:0]        burst_q;
    logic              last_beat;
    logic              wrap_ok;
    logic              unused_id;

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

`ifdef AXI_BURST_WRAP_EN
    logic [BW:0] beats;
    assign beats   = {1'b0, req_len} + 1'b1;
    // WRAP only for 2/4/8/16 beats; anything else quietly stays INCR
    assign wrap_ok = req_wrap && (req_len != '0) && ((beats & (beats - 1'b1)) == '0);
`else
    logic unused_wrap;
    assign unused_wrap = req_wrap;
    assign wrap_ok     = 1'b0;
`endif

    assign unused_id = ^{RID, BID};
    assign last_beat = cnt_q == len_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 2'b00;
            burst_q <= 2'b01;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    addr_q  <= req_addr & AMASK;
                    len_q   <= req_len;
                    burst_q <= wrap_ok ? 2'b10 : 2'b01;
                    err_q   <= 2'b00;
                    cnt_q   <= '0;
                    state_q <= req_write ? S_AW : S_AR;
                end
                S_AR: if (ARREADY) begin
                    cnt_q   <= '0;
                    state_q <= S_R;
                end
                S_R: if (RVALID) begin
                    cnt_q <= cnt_q + 1'b1;
                    // an RLAST that disagrees with our own beat count is a protocol error
                    err_q <= worst(worst(err_q, RRESP), (RLAST != last_beat) ? 2'b10 : 2'b00);
                    if (RLAST || last_beat) state_q <= S_DONE;
                end
                S_AW: if (AWREADY) begin
                    cnt_q   <= '0;
                    state_q <= S_W;
                end
                S_W: if (WREADY) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last_beat) state_q <= S_B;
                end
                S_B: if (BVALID) begin
                    err_q   <= worst(err_q, BRESP);
                    state_q <= S_DONE;
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall       = (state_q != S_IDLE && state_q != S_DONE) || (state_q == S_IDLE && req_valid);
    assign done        = state_q == S_DONE;
    assign err         = err_q;
    assign rbeat_valid = (state_q == S_R) && RVALID;
    assign rbeat_idx   = cnt_q;
    assign rbeat_data  = RDATA;
    assign wbeat_idx   = cnt_q;

    assign ARID    = AXI_ID;
    assign ARADDR  = addr_q;
    assign ARLEN   = 4'(len_q);
    assign ARSIZE  = 3'(SZ);
    assign ARBURST = burst_q;
    assign ARVALID = state_q == S_AR;
    assign RREADY  = state_q == S_R;

    assign AWID    = AXI_ID;
    assign AWADDR  = addr_q;
    assign AWLEN   = 4'(len_q);
    assign AWSIZE  = 3'(SZ);
    assign AWBURST = burst_q;
    assign AWVALID = state_q == S_AW;

    assign WDATA  = req_wdata;
    assign WSTRB  = req_strb;
    assign WLAST  = (state_q == S_W) && last_beat;
    assign WVALID = state_q == S_W;
    assign BREADY = state_q == S_B;
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed bursts against a small AXI slave model; beats are checked through queues
// of expected read/write beats filled when each request is issued.
module tb_axi_burst_master;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int BW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic ARESETn = 1'b0;
    logic req_valid = 1'b0, req_write = 1'b0, req_wrap = 1'b0;
    logic [31:0] req_addr = '0;
    logic [BW-1:0] req_len = '0;
    logic [SW-1:0] req_strb = '0;
    logic [DW-1:0] req_wdata;
    logic stall, done, rbeat_valid;
    logic [1:0] err;
    logic [BW-1:0] rbeat_idx, wbeat_idx;
    logic [DW-1:0] rbeat_data;
    logic [3:0] ARID, ARLEN, AWID, AWLEN;
    logic [31:0] ARADDR, AWADDR;
    logic [2:0] ARSIZE, AWSIZE;
    logic [1:0] ARBURST, AWBURST;
    logic ARVALID, RREADY, AWVALID, WLAST, WVALID, BREADY;
    logic ARREADY = 1'b0, RLAST = 1'b0, RVALID = 1'b0, AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
    logic [3:0] RID = 4'd0, BID = 4'd0;
    logic [DW-1:0] RDATA = '0;
    logic [1:0] RRESP = 2'b00, BRESP = 2'b00;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;

    logic [DW-1:0] wdata_tab [4];
    logic [DW-1:0] rdata_tab [4];
    assign req_wdata = wdata_tab[wbeat_idx];

    axi_burst_master dut (
        .ACLK(clk), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_strb(req_strb), .req_wdata(req_wdata), .req_wrap(req_wrap),
        .stall(stall), .done(done), .err(err),
        .rbeat_valid(rbeat_valid), .rbeat_idx(rbeat_idx), .rbeat_data(rbeat_data), .wbeat_idx(wbeat_idx),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {logic [BW-1:0] idx; logic [DW-1:0] data;} rexp_t;
    typedef struct packed {logic [BW-1:0] idx; logic [DW-1:0] data; logic [SW-1:0] strb; logic last;} wexp_t;
    rexp_t rq[$];
    wexp_t wq[$];

    // slave knobs (written by the stimulus) and expected address-channel fields
    int ar_wait = 0, aw_wait = 0, r_n = 0, r_last = 0;
    logic [1:0] r_resp = 2'b00, b_resp = 2'b00;
    logic [31:0] exp_addr = '0;
    logic [3:0] exp_len = '0;
    logic [1:0] exp_burst = 2'b01;

    // slave/monitor state (written only by the monitor)
    int ar_cnt = 0, aw_cnt = 0, r_i = 0, aw_cycles = 0, b_hs = 0;
    bit aw_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        rexp_t re;
        wexp_t we;
        ARREADY = ARVALID && ar_cnt >= ar_wait;
        AWREADY = AWVALID && aw_cnt >= aw_wait;
        WREADY  = 1'b1;
        RVALID  = RREADY && r_i < r_n;
        RDATA   = rdata_tab[2'(r_i)];
        RLAST   = RVALID && r_i == r_last;
        RRESP   = r_resp;
        BVALID  = BREADY;
        BRESP   = b_resp;
        #1;
        if (!ARESETn) begin
            ar_cnt = 0; aw_cnt = 0; r_i = 0; aw_done = 1'b0;
        end else begin
            ar_cnt = (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
            aw_cnt = (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
            if (ARVALID) begin
                chk("araddr", ARADDR, exp_addr);
                chk("arlen", ARLEN, exp_len);
                chk("arsize", ARSIZE, 3'd2);
                chk("arburst", ARBURST, exp_burst);
                chk("arid", ARID, 4'd0);
            end
            if (WVALID) chk("w_after_aw", aw_done, 1'b1);
            if (AWVALID) begin
                aw_cycles++;
                chk("awaddr", AWADDR, exp_addr);
                chk("awlen", AWLEN, exp_len);
                chk("awsize", AWSIZE, 3'd2);
                chk("awburst", AWBURST, exp_burst);
                if (AWREADY) aw_done = 1'b1;
            end
            if (RVALID && RREADY) begin
                chk("rbeat_valid", rbeat_valid, 1'b1);
                checks++;
                assert (rq.size() > 0) else begin
                    failures++;
                    $error("FAIL r_unexpected observed=idx%0d expected=no_beat", rbeat_idx);
                end
                if (rq.size() > 0) begin
                    re = rq.pop_front();
                    chk("rbeat_idx", rbeat_idx, re.idx);
                    chk("rbeat_data", rbeat_data, re.data);
                end
                r_i++;
            end else begin
                chk("rbeat_quiet", rbeat_valid, 1'b0);
                if (!RREADY) r_i = 0;
            end
            if (WVALID && WREADY) begin
                checks++;
                assert (wq.size() > 0) else begin
                    failures++;
                    $error("FAIL w_unexpected observed=idx%0d expected=no_beat", wbeat_idx);
                end
                if (wq.size() > 0) begin
                    we = wq.pop_front();
                    chk("wbeat_idx", wbeat_idx, we.idx);
                    chk("wdata", WDATA, we.data);
                    chk("wstrb", WSTRB, we.strb);
                    chk("wlast", WLAST, we.last);
                end
            end
            if (BVALID && BREADY) b_hs++;
            if (done) aw_done = 1'b0;
        end
    end

    task automatic push_reads(input int n);
        for (int i = 0; i < 4; i++) rdata_tab[i] = $urandom;
        for (int i = 0; i < n; i++) rq.push_back('{idx: BW'(i), data: rdata_tab[i]});
    endtask

    task automatic push_writes(input int n, input int len, input logic [SW-1:0] strb);
        for (int i = 0; i < 4; i++) wdata_tab[i] = $urandom;
        for (int i = 0; i < n; i++) wq.push_back('{idx: BW'(i), data: wdata_tab[i], strb: strb, last: (i == len)});
    endtask

    task automatic drive(input bit wr, input logic [31:0] addr, input int len, input logic [SW-1:0] strb, input bit wrap);
        @(posedge clk); #2;
        req_write = wr; req_addr = addr; req_len = BW'(len); req_strb = strb; req_wrap = wrap;
        req_valid = 1'b1;
    endtask

    // runs one request to completion; cycle 0 is the cycle the request is first presented
    task automatic run(input bit wr, input logic [31:0] addr, input int len, input logic [SW-1:0] strb,
                       input bit wrap, output int dk, output logic [1:0] derr);
        dk = -1;
        derr = 2'bxx;
        drive(wr, addr, len, strb, wrap);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #3;
            if (done) begin
                dk = k;
                derr = err;
                break;
            end
            chk("stall_busy", stall, 1'b1);
        end
        if (dk < 0) chk("done_seen", done, 1'b1);
        else chk("stall_at_done", stall, 1'b0);
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(negedge clk); #3;
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        int dk, a0, b0;
        logic [1:0] de;
        for (int i = 0; i < 4; i++) begin wdata_tab[i] = '0; rdata_tab[i] = '0; end
        repeat (2) @(negedge clk);
        #3;
        chk("rst_arvalid", ARVALID, 1'b0);
        chk("rst_awvalid", AWVALID, 1'b0);
        chk("rst_wvalid", WVALID, 1'b0);
        chk("rst_rready", RREADY, 1'b0);
        chk("rst_bready", BREADY, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 2'b00);
        chk("rst_rbeat_valid", rbeat_valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_arburst", ARBURST, 2'b01);
        chk("rst_awburst", AWBURST, 2'b01);
        chk("rst_araddr", ARADDR, 32'h0);
        chk("rst_arlen", ARLEN, 4'h0);
        chk("rst_wbeat_idx", wbeat_idx, 2'd0);
        @(posedge clk); #2;
        ARESETn = 1'b1;

        // 4-beat INCR read, zero-wait slave
        exp_addr = 32'h1004; exp_len = 4'd3; exp_burst = 2'b01;
        ar_wait = 0; r_n = 4; r_last = 3; r_resp = 2'b00;
        push_reads(4);
        run(1'b0, 32'h1004, 3, '0, 1'b0, dk, de);
        chk("rd4_done_cycle", dk, 6);
        chk("rd4_err", de, 2'b00);
        chk("rd4_all_beats", rq.size(), 0);

        // 2-beat write with AWREADY held off for 3 cycles
        exp_addr = 32'h1000_0040; exp_len = 4'd1; exp_burst = 2'b01;
        aw_wait = 3; b_resp = 2'b00;
        push_writes(2, 1, 4'b0011);
        a0 = aw_cycles; b0 = b_hs;
        run(1'b1, 32'h1000_0040, 1, 4'b0011, 1'b0, dk, de);
        chk("wr2_awvalid_cycles", aw_cycles - a0, 4);
        chk("wr2_b_handshake", b_hs - b0, 1);
        chk("wr2_done_cycle", dk, 8);
        chk("wr2_err", de, 2'b00);
        chk("wr2_all_beats", wq.size(), 0);

        // single-beat read returning SLVERR; unaligned address is forced down to the word
        exp_addr = 32'h3000; exp_len = 4'd0;
        r_n = 1; r_last = 0; r_resp = 2'b10;
        push_reads(1);
        run(1'b0, 32'h3003, 0, '0, 1'b0, dk, de);
        chk("rd1_done_cycle", dk, 3);
        chk("rd1_err", de, 2'b10);

        // next request starts with a clean error
        exp_addr = 32'h3010; exp_len = 4'd1;
        r_n = 2; r_last = 1; r_resp = 2'b00;
        push_reads(2);
        run(1'b0, 32'h3010, 1, '0, 1'b0, dk, de);
        chk("rd2_done_cycle", dk, 4);
        chk("rd2_err_cleared", de, 2'b00);

        // slave ends a 4-beat read early with RLAST on beat 1
        exp_addr = 32'h4000; exp_len = 4'd3;
        r_n = 2; r_last = 1; r_resp = 2'b00;
        push_reads(2);
        run(1'b0, 32'h4000, 3, '0, 1'b0, dk, de);
        chk("early_last_done_cycle", dk, 4);
        chk("early_last_err", de, 2'b10);
        chk("early_last_beats", rq.size(), 0);

        // reset dropped while write beat 2 is on the bus
        exp_addr = 32'h5000; exp_len = 4'd3;
        aw_wait = 0;
        push_writes(3, 3, 4'b1111);
        drive(1'b1, 32'h5000, 3, 4'b1111, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #3;
            if (WVALID && wbeat_idx == 2'd2) break;
        end
        chk("reset_at_beat2", wbeat_idx, 2'd2);
        ARESETn = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("abort_wvalid", WVALID, 1'b0);
        chk("abort_awvalid", AWVALID, 1'b0);
        chk("abort_bready", BREADY, 1'b0);
        chk("abort_stall", stall, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_wbeat_idx", wbeat_idx, 2'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #3;
            chk("abort_no_done", done, 1'b0);
        end
        @(posedge clk); #2;
        ARESETn = 1'b1;
        @(negedge clk); #3;
        chk("abort_idle_done", done, 1'b0);
        chk("abort_idle_stall", stall, 1'b0);
        chk("abort_wq_drained", wq.size(), 0);

        exp_addr = 32'h6000; exp_len = 4'd1;
        r_n = 2; r_last = 1; r_resp = 2'b00;
        push_reads(2);
        run(1'b0, 32'h6000, 1, '0, 1'b0, dk, de);
        chk("post_rst_done_cycle", dk, 4);
        chk("post_rst_err", de, 2'b00);

        // WRAP request with a legal and an illegal length
        exp_addr = 32'h2008; exp_len = 4'd3;
`ifdef AXI_BURST_WRAP_EN
        exp_burst = 2'b10;
`else
        exp_burst = 2'b01;
`endif
        r_n = 4; r_last = 3;
        push_reads(4);
        run(1'b0, 32'h2008, 3, '0, 1'b1, dk, de);
        chk("wrap4_done_cycle", dk, 6);
        exp_len = 4'd2; exp_burst = 2'b01;
        r_n = 3; r_last = 2;
        push_reads(3);
        run(1'b0, 32'h2008, 2, '0, 1'b1, dk, de);
        chk("wrap3_done_cycle", dk, 5);
        chk("final_rq_empty", rq.size(), 0);
        chk("final_wq_empty", wq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
